// File: rtl/pc_sequencer_pkg.sv
// Shared miniRISC sequencer definitions: state encodings, PC reset vector and fetch limits.
// RESET_VEC must equal the PC register reset value so that BOOT lands the first fetch on 0.
package pc_sequencer_pkg;

   localparam int          DEF_ADDR_W   = 32;
   localparam int          INSTR_BYTES  = 4;
   localparam int          DEF_MAX_WAIT = 15;
   localparam int          WAIT_W       = 4;
   localparam logic [31:0] RESET_VEC    = 32'hFFFF_FFFC;

   typedef enum logic [2:0] {
      ST_BOOT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_HALTED = 3'd3,
      ST_ERROR  = 3'd4
   } seq_state_e;

   function automatic logic word_aligned(input logic [1:0] lsb);
      return lsb == 2'b00;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port between the sequencer (master) and instruction memory (slave).
// imem_req is high for every FETCH cycle; instr_in is taken in the first cycle with imem_req && imem_ack.
interface pc_sequencer_if;

   logic        imem_req;
   logic        imem_ack;
   logic [31:0] instr_in;

   modport master (output imem_req, input imem_ack, input instr_in);
   modport slave  (input imem_req, output imem_ack, output instr_in);

endinterface

// File: rtl/pc_sequencer_fetch_watchdog.sv
// Counts FETCH cycles without an acknowledge; timeout flags the last permitted cycle.
// The FSM gives a same-cycle ack priority over timeout.
module fetch_watchdog
   import pc_sequencer_pkg::*;
#(
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ack,
   output logic timeout
);

   logic [WAIT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!active || ack) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + WAIT_W'(1);
      end
   end

   // cnt holds the number of earlier unacknowledged cycles, so MAX_WAIT-1 marks cycle MAX_WAIT
   assign timeout = active && (cnt == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// miniRISC fetch/execute sequencer: owns the PC update policy, the fetch handshake,
// the instruction register, HALT/resume, fetch-timeout error and the retired-instruction count.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic              clk,
   input  logic              rst,
   pc_sequencer_if.master    imem,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic [ADDR_W-1:0] pc_next,
   output logic [31:0]       ir,
   output logic              ir_valid,
   input  logic              exec_done,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              halt_instr,
   input  logic              resume,
   output logic [31:0]       retire_cnt,
   output logic              fetch_err,
   output logic [2:0]        state
);

   seq_state_e        cur_st, nxt_st;
   logic              req;
   logic              ir_load;
   logic              retire;
   logic              fetch_timeout;
   logic [ADDR_W-1:0] pc_inc;

   assign pc_inc        = pc_cur + ADDR_W'(INSTR_BYTES);
   assign imem.imem_req = req;
   assign state         = cur_st;

   fetch_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .active  (cur_st == ST_FETCH),
      .ack     (imem.imem_ack),
      .timeout (fetch_timeout)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_st <= ST_BOOT;
      end else begin
         cur_st <= nxt_st;
      end
   end

   always_comb begin
      nxt_st    = cur_st;
      pc_next   = pc_cur;
      req       = 1'b0;
      ir_valid  = 1'b0;
      fetch_err = 1'b0;
      ir_load   = 1'b0;
      retire    = 1'b0;
      case (cur_st)
         ST_BOOT: begin
            pc_next = pc_inc;
            nxt_st  = ST_FETCH;
         end
         ST_FETCH: begin
            req = 1'b1;
            if (imem.imem_ack) begin
               ir_load = 1'b1;
               nxt_st  = ST_EXEC;
            end else if (fetch_timeout) begin
               nxt_st = ST_ERROR;
            end
         end
         ST_EXEC: begin
            ir_valid = 1'b1;
            if (exec_done && !stall) begin
               // HALT outranks a simultaneous branch; a misaligned target retires nothing
               if (halt_instr) begin
                  pc_next = pc_inc;
                  retire  = 1'b1;
                  nxt_st  = ST_HALTED;
               end else if (br_taken && !word_aligned(br_target[1:0])) begin
                  nxt_st = ST_ERROR;
               end else begin
                  pc_next = br_taken ? br_target : pc_inc;
                  retire  = 1'b1;
                  nxt_st  = ST_FETCH;
               end
            end
         end
         ST_HALTED: begin
            if (resume) begin
               nxt_st = ST_FETCH;
            end
         end
         ST_ERROR: begin
            fetch_err = 1'b1;
         end
         default: begin
            nxt_st = ST_ERROR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir         <= '0;
         retire_cnt <= '0;
      end else begin
         if (ir_load) begin
            ir <= imem.instr_in;
         end
         if (retire) begin
            retire_cnt <= retire_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a PC register model closes the loop, expected state/PC
// records are queued by the stimulus and popped by a monitor whenever the state or pc_next changes.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   localparam int REC_W = 134;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_cur, pc_next, ir, br_target, retire_cnt;
   logic        ir_valid, exec_done, stall, br_taken, halt_instr, resume, fetch_err;
   logic [2:0]  dut_state;

   logic [REC_W-1:0] exp_q[$];
   logic [REC_W-1:0] act_rec, exp_rec;
   logic [2:0]       last_state = 3'd7;
   logic             mon_en = 1'b0;
   logic             end_req = 1'b0;
   logic             end_done = 1'b0;
   int               checks = 0;
   int               errors = 0;

   always #5 clk = ~clk;

   pc_sequencer_if imem ();

   pc_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .imem       (imem),
      .pc_cur     (pc_cur),
      .pc_next    (pc_next),
      .ir         (ir),
      .ir_valid   (ir_valid),
      .exec_done  (exec_done),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .halt_instr (halt_instr),
      .resume     (resume),
      .retire_cnt (retire_cnt),
      .fetch_err  (fetch_err),
      .state      (dut_state)
   );

   // PC register that the sequencer steers; resets to the same vector as the real one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_cur <= RESET_VEC;
      end else begin
         pc_cur <= pc_next;
      end
   end

   function automatic logic [REC_W-1:0] mk(input logic [2:0] st, input logic req, input logic irv,
                                           input logic err, input logic [31:0] pc, input logic [31:0] pcn,
                                           input logic [31:0] irw, input logic [31:0] rc);
      return {st, req, irv, err, pc, pcn, irw, rc};
   endfunction

   task automatic push_rst();
      exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'd0));
   endtask

   task automatic push_fetch(input logic [31:0] pc, input logic [31:0] irw, input logic [31:0] rc);
      exp_q.push_back(mk(3'd1, 1'b1, 1'b0, 1'b0, pc, pc, irw, rc));
   endtask

   task automatic push_exec(input logic [31:0] pc, input logic [31:0] pcn, input logic [31:0] irw,
                            input logic [31:0] rc);
      exp_q.push_back(mk(3'd2, 1'b0, 1'b1, 1'b0, pc, pcn, irw, rc));
   endtask

   task automatic push_halt(input logic [31:0] pc, input logic [31:0] irw, input logic [31:0] rc);
      exp_q.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, pc, pc, irw, rc));
   endtask

   task automatic push_err(input logic [31:0] pc, input logic [31:0] irw, input logic [31:0] rc);
      exp_q.push_back(mk(3'd4, 1'b0, 1'b0, 1'b1, pc, pc, irw, rc));
   endtask

   // n >= 1 rising edges, then settle 1 time unit past the edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-negedge reset pulse with a stray ack that must be discarded; ends in FETCH at pc 0
   task automatic do_reset();
      @(negedge clk);
      #1;
      rst            = 1'b0;
      mon_en         = 1'b1;
      imem.imem_ack  = 1'b1;
      exec_done      = 1'b0;
      stall          = 1'b0;
      br_taken       = 1'b0;
      halt_instr     = 1'b0;
      resume         = 1'b0;
      push_rst();
      @(negedge clk);
      #1;
      rst           = 1'b1;
      imem.imem_ack = 1'b0;
      push_fetch(32'h0, 32'h0, 32'd0);
      step(1);
   endtask

   // Fetch after wait_cyc unacknowledged cycles, then complete in the first EXEC cycle
   task automatic issue(input logic [31:0] instr, input int wait_cyc, input logic br,
                        input logic [31:0] tgt, input logic halt);
      if (wait_cyc > 0) step(wait_cyc);
      imem.imem_ack = 1'b1;
      imem.instr_in = instr;
      exec_done     = 1'b1;
      br_taken      = br;
      br_target     = tgt;
      halt_instr    = halt;
      step(1);
      imem.imem_ack = 1'b0;
      step(1);
      exec_done  = 1'b0;
      br_taken   = 1'b0;
      halt_instr = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (!rst || dut_state != last_state || pc_next != pc_cur) begin
            act_rec = mk(dut_state, imem.imem_req, ir_valid, fetch_err, pc_cur, pc_next, ir, retire_cnt);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event t=%0t got=%h required=none", $time, act_rec);
            end else begin
               exp_rec = exp_q.pop_front();
               if (act_rec !== exp_rec) begin
                  errors++;
                  $display("FAIL event_%0d t=%0t got=%h required=%h", checks, $time, act_rec, exp_rec);
               end
            end
         end
         last_state = rst ? dut_state : 3'd7;
         if (end_req && !end_done) begin
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL queue_drain got=%0d pending required=0", exp_q.size());
            end
            end_done = 1'b1;
         end
      end
   end

   initial begin
      imem.imem_ack = 1'b0;
      imem.instr_in = 32'h0;
      exec_done     = 1'b0;
      stall         = 1'b0;
      br_taken      = 1'b0;
      br_target     = 32'h0;
      halt_instr    = 1'b0;
      resume        = 1'b0;

      // reset: BOOT steers FFFFFFFC -> 0, then FETCH requests from 0
      do_reset();

      // ack three cycles after the request, sequential advance 0 -> 4
      push_exec(32'h0, 32'h4, 32'h1234_5678, 32'd0);
      push_fetch(32'h4, 32'h1234_5678, 32'd1);
      issue(32'h1234_5678, 3, 1'b0, 32'h0, 1'b0);

      // aligned branch, then misaligned branch into a sticky ERROR
      push_exec(32'h4, 32'h40, 32'hA000_0001, 32'd1);
      push_fetch(32'h40, 32'hA000_0001, 32'd2);
      issue(32'hA000_0001, 0, 1'b1, 32'h40, 1'b0);
      push_exec(32'h40, 32'h40, 32'hA000_0002, 32'd2);
      push_err(32'h40, 32'hA000_0002, 32'd2);
      issue(32'hA000_0002, 1, 1'b1, 32'h42, 1'b0);
      resume        = 1'b1;
      exec_done     = 1'b1;
      imem.imem_ack = 1'b1;
      step(4);
      resume        = 1'b0;
      exec_done     = 1'b0;
      imem.imem_ack = 1'b0;
      do_reset();

      // HALT beats a simultaneous branch at pc 0x10, resume continues from 0x14
      push_exec(32'h0, 32'h10, 32'hB000_0001, 32'd0);
      push_fetch(32'h10, 32'hB000_0001, 32'd1);
      issue(32'hB000_0001, 0, 1'b1, 32'h10, 1'b0);
      push_exec(32'h10, 32'h14, 32'hF000_0000, 32'd1);
      push_halt(32'h14, 32'hF000_0000, 32'd2);
      issue(32'hF000_0000, 0, 1'b1, 32'h80, 1'b1);
      exec_done     = 1'b1;
      imem.imem_ack = 1'b1;
      step(3);
      exec_done     = 1'b0;
      imem.imem_ack = 1'b0;
      push_fetch(32'h14, 32'hF000_0000, 32'd2);
      resume = 1'b1;
      step(1);
      resume = 1'b0;
      push_exec(32'h14, 32'h18, 32'hC000_0001, 32'd2);
      push_fetch(32'h18, 32'hC000_0001, 32'd3);
      issue(32'hC000_0001, 1, 1'b0, 32'h0, 1'b0);

      // stall blocks the EXEC exit for 4 cycles; pc FFFFFFFC then wraps to 0
      push_exec(32'h18, 32'hFFFF_FFFC, 32'hD000_0001, 32'd3);
      push_fetch(32'hFFFF_FFFC, 32'hD000_0001, 32'd4);
      issue(32'hD000_0001, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      push_exec(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0013, 32'd4);
      push_exec(32'hFFFF_FFFC, 32'h0, 32'h0000_0013, 32'd4);
      push_fetch(32'h0, 32'h0000_0013, 32'd5);
      imem.imem_ack = 1'b1;
      imem.instr_in = 32'h0000_0013;
      exec_done     = 1'b1;
      stall         = 1'b1;
      step(1);
      imem.imem_ack = 1'b0;
      step(4);
      stall = 1'b0;
      step(1);
      exec_done = 1'b0;

      // 15 unacknowledged FETCH cycles end in ERROR; reset lands right after the 15th
      push_err(32'h0, 32'h0000_0013, 32'd5);
      step(15);
      do_reset();

      // ack on the 15th FETCH cycle wins over the timeout
      push_exec(32'h0, 32'h4, 32'hE000_0001, 32'd0);
      push_fetch(32'h4, 32'hE000_0001, 32'd1);
      issue(32'hE000_0001, 14, 1'b0, 32'h0, 1'b0);

      step(3);
      end_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
